// File: rtl/tdd_frame_sched_pkg.sv
// rtl/tdd_frame_sched_pkg.sv - shared state encoding and default sizing for the TDD frame scheduler
package tdd_frame_sched_pkg;

    localparam int CW_DEFAULT     = 24;
    localparam int MINLEN_DEFAULT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tdd_frame_sched_if.sv
// rtl/tdd_frame_sched_if.sv - frame config inputs and stream-engine enables of the TDD scheduler
interface tdd_frame_sched_if
    import tdd_frame_sched_pkg::*;
#(
    parameter int CW = CW_DEFAULT
);
    logic          run;
    logic          tddmode;
    logic [CW-1:0] frame_len;
    logic [CW-1:0] frame_adj;
    logic          adj_req;
    logic [CW-1:0] rstart;
    logic [CW-1:0] rend;
    logic [CW-1:0] tstart;
    logic [CW-1:0] tend;
    logic          ien;
    logic          oen;
    logic          sync;
    logic [CW-1:0] fcnt;
    logic          adj_pending;

    modport master (
        output run, tddmode, frame_len, frame_adj, adj_req, rstart, rend, tstart, tend,
        input  ien, oen, sync, fcnt, adj_pending
    );

    modport slave (
        input  run, tddmode, frame_len, frame_adj, adj_req, rstart, rend, tstart, tend,
        output ien, oen, sync, fcnt, adj_pending
    );

endinterface

// File: rtl/tdd_win.sv
// rtl/tdd_win.sv - registered half-open window compare [win_start, win_end) against the next count
module tdd_win
    import tdd_frame_sched_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active,
    input  logic          tdd,
    input  logic [CW-1:0] win_start,
    input  logic [CW-1:0] win_end,
    input  logic [CW-1:0] cnt,
    output logic          en
);

    logic en_q;
    logic en_d;

    // start >= end yields an empty window; FDD keeps the path open for every running cycle
    always_comb begin
        en_d = active && (!tdd || ((cnt >= win_start) && (cnt < win_end)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    assign en = en_q;

endmodule

// File: rtl/tdd_frame_sched.sv
// rtl/tdd_frame_sched.sv - frame counter, shadow config, one-shot length adjust and window enables
module tdd_frame_sched
    import tdd_frame_sched_pkg::*;
#(
    parameter int CW     = CW_DEFAULT,
    parameter int MINLEN = MINLEN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    tdd_frame_sched_if.slave   bus
);

    state_e        state_q, state_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] slen_q, slen_d;
    logic          stdd_q, stdd_d;
    logic [CW-1:0] rstart_q, rstart_d;
    logic [CW-1:0] rend_q, rend_d;
    logic [CW-1:0] tstart_q, tstart_d;
    logic [CW-1:0] tend_q, tend_d;
    logic [CW-1:0] adj_q, adj_d;
    logic          pend_q, pend_d;
    logic          sync_q, sync_d;

    logic          boundary;
    logic          load;
    logic          apply_adj;
    logic [CW+1:0] adj_term;
    logic [CW+1:0] sum;
    logic [CW-1:0] len_new;

    always_comb begin
        boundary  = (state_q == ST_RUN) && (fcnt_q == len_q - CW'(1));
        load      = bus.run && ((state_q == ST_IDLE) || boundary);
        apply_adj = load && boundary && pend_q;
        state_d   = bus.run ? ST_RUN : ST_IDLE;

        slen_d    = load ? bus.frame_len : slen_q;
        stdd_d    = load ? bus.tddmode   : stdd_q;
        rstart_d  = load ? bus.rstart    : rstart_q;
        rend_d    = load ? bus.rend      : rend_q;
        tstart_d  = load ? bus.tstart    : tstart_q;
        tend_d    = load ? bus.tend      : tend_q;

        // two spare bits keep the sign and any carry past CW, so both ends can be clamped
        adj_term = apply_adj ? {{2{adj_q[CW-1]}}, adj_q} : '0;
        sum      = {2'b00, bus.frame_len} + adj_term;
        if (sum[CW+1]) begin
            len_new = CW'(MINLEN);
        end else if (sum[CW]) begin
            len_new = '1;
        end else if (sum[CW-1:0] < CW'(MINLEN)) begin
            len_new = CW'(MINLEN);
        end else begin
            len_new = sum[CW-1:0];
        end
        len_d = load ? len_new : len_q;

        fcnt_d = ((state_d == ST_IDLE) || load) ? '0 : fcnt_q + CW'(1);
        sync_d = (state_d == ST_RUN) && (fcnt_d == '0);

        // a request in the boundary cycle wins over the clear, so it waits for the next boundary
        adj_d  = bus.adj_req ? bus.frame_adj : adj_q;
        pend_d = bus.adj_req ? 1'b1 : (apply_adj ? 1'b0 : pend_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fcnt_q   <= '0;
            len_q    <= '0;
            slen_q   <= '0;
            stdd_q   <= 1'b0;
            rstart_q <= '0;
            rend_q   <= '0;
            tstart_q <= '0;
            tend_q   <= '0;
            adj_q    <= '0;
            pend_q   <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            len_q    <= len_d;
            slen_q   <= slen_d;
            stdd_q   <= stdd_d;
            rstart_q <= rstart_d;
            rend_q   <= rend_d;
            tstart_q <= tstart_d;
            tend_q   <= tend_d;
            adj_q    <= adj_d;
            pend_q   <= pend_d;
            sync_q   <= sync_d;
        end
    end

    logic rx_en;
    logic tx_en;
    logic win_active;

    assign win_active = (state_d == ST_RUN);

    tdd_win #(.CW(CW)) u_rx_win (
        .clk       (clk),
        .rst       (rst),
        .active    (win_active),
        .tdd       (stdd_d),
        .win_start (rstart_d),
        .win_end   (rend_d),
        .cnt       (fcnt_d),
        .en        (rx_en)
    );

    tdd_win #(.CW(CW)) u_tx_win (
        .clk       (clk),
        .rst       (rst),
        .active    (win_active),
        .tdd       (stdd_d),
        .win_start (tstart_d),
        .win_end   (tend_d),
        .cnt       (fcnt_d),
        .en        (tx_en)
    );

    assign bus.ien         = rx_en;
    assign bus.oen         = tx_en;
    assign bus.sync        = sync_q;
    assign bus.fcnt        = fcnt_q;
    assign bus.adj_pending = pend_q;

    // slen_q mirrors the loaded frame length; len_q is the value actually counted against
    logic unused_slen;
    assign unused_slen = ^slen_q;

endmodule

// File: tb/tb_tdd_frame_sched.sv
// tb/tb_tdd_frame_sched.sv - scoreboard bench for the TDD frame scheduler
module tb_tdd_frame_sched;

    localparam int CW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tdd_frame_sched_if #(.CW(CW)) bus ();

    tdd_frame_sched #(.CW(CW), .MINLEN(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [CW+3:0] exp_q[$];
    logic [CW+3:0] got;
    logic [CW+3:0] want;

    function automatic logic [CW+3:0] pack_exp(input bit s, input bit i, input bit o,
                                               input bit p, input int f);
        return {s, i, o, p, CW'(f)};
    endfunction

    function automatic void push_exp(input bit s, input bit i, input bit o, input bit p, input int f);
        exp_q.push_back(pack_exp(s, i, o, p, f));
    endfunction

    // whole frame of expected outputs; adj_pending reads 1 from sample pfrom on
    function automatic void push_frame(input int len, input int pfrom, input int rs, input int re,
                                       input int ts, input int te, input bit tdd);
        for (int k = 0; k < len; k++) begin
            push_exp(k == 0, tdd ? (k >= rs && k < re) : 1'b1,
                     tdd ? (k >= ts && k < te) : 1'b1, k >= pfrom, k);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int len, input int rs, input int re, input int ts, input int te,
                           input bit tdd);
        bus.frame_len = CW'(len);
        bus.rstart    = CW'(rs);
        bus.rend      = CW'(re);
        bus.tstart    = CW'(ts);
        bus.tend      = CW'(te);
        bus.tddmode   = tdd;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.adj_req = 1'b0;
        cyc();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        set_cfg(10, 2, 5, 6, 9, 1'b1);
        bus.run       = 1'b1;
        bus.adj_req   = 1'b1;
        bus.frame_adj = CW'(7);
        cyc();
        cyc();
        got = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", got, {(CW+4){1'b0}});
        end
        rst         = 1'b0;
        bus.run     = 1'b0;
        bus.adj_req = 1'b0;
        cyc();
        got = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL idle_state got=%h want=%h", got, {(CW+4){1'b0}});
        end
        bus.adj_req = 1'b1;
        cyc();
        bus.adj_req = 1'b0;
        want = pack_exp(0, 0, 0, 1, 0);
        got  = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL idle_adj_capture got=%h want=%h", got, want);
        end
        do_reset();
        got = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_clears_pending got=%h want=%h", got, {(CW+4){1'b0}});
        end
    endtask

    task automatic test_tdd_windows();
        do_reset();
        set_cfg(10, 2, 5, 6, 9, 1'b1);
        for (int f = 0; f < 3; f++) push_frame(10, 99, 2, 5, 6, 9, 1'b1);
        bus.run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            got  = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL tdd_windows i=%0d got=%h want=%h", i, got, want);
            end
        end
        bus.run = 1'b0;
        cyc();
        got = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL tdd_stop got=%h want=%h", got, {(CW+4){1'b0}});
        end
    endtask

    task automatic test_fdd_and_minlen();
        do_reset();
        set_cfg(10, 2, 5, 6, 9, 1'b0);
        push_frame(10, 99, 0, 0, 0, 0, 1'b0);
        push_frame(10, 99, 0, 0, 0, 0, 1'b0);
        for (int f = 0; f < 3; f++) push_frame(2, 99, 0, 0, 0, 0, 1'b0);
        bus.run = 1'b1;
        for (int i = 0; i < 26; i++) begin
            cyc();
            got  = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fdd_minlen i=%0d got=%h want=%h", i, got, want);
            end
            if (i == 15) bus.frame_len = CW'(1);
        end
        bus.run = 1'b0;
    endtask

    task automatic test_adjust_mid_frame();
        do_reset();
        set_cfg(10, 2, 5, 6, 9, 1'b1);
        bus.frame_adj = CW'(-3);
        push_frame(10, 4, 2, 5, 6, 9, 1'b1);
        push_frame(7, 99, 2, 5, 6, 9, 1'b1);
        push_frame(10, 99, 2, 5, 6, 9, 1'b1);
        bus.run = 1'b1;
        for (int i = 0; i < 27; i++) begin
            cyc();
            got  = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL adjust_mid i=%0d got=%h want=%h", i, got, want);
            end
            bus.adj_req = (i == 3);
        end
        bus.run     = 1'b0;
        bus.adj_req = 1'b0;
    endtask

    task automatic test_adjust_boundary();
        do_reset();
        set_cfg(10, 2, 5, 6, 9, 1'b1);
        push_frame(10, 99, 2, 5, 6, 9, 1'b1);
        push_frame(10, 0, 2, 5, 6, 9, 1'b1);
        push_frame(15, 6, 2, 5, 6, 9, 1'b1);
        push_frame(2, 99, 2, 5, 6, 9, 1'b1);
        push_frame(10, 99, 2, 5, 6, 9, 1'b1);
        bus.run = 1'b1;
        for (int i = 0; i < 47; i++) begin
            cyc();
            got  = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL adjust_boundary i=%0d got=%h want=%h", i, got, want);
            end
            bus.adj_req   = (i == 9) || (i == 25);
            bus.frame_adj = (i == 9) ? CW'(5) : CW'(-20);
        end
        bus.run     = 1'b0;
        bus.adj_req = 1'b0;
    endtask

    task automatic test_shadow_update();
        do_reset();
        set_cfg(10, 2, 5, 6, 9, 1'b1);
        push_frame(10, 99, 2, 5, 6, 9, 1'b1);
        push_frame(10, 99, 2, 8, 6, 9, 1'b1);
        push_frame(10, 99, 4, 4, 6, 9, 1'b1);
        bus.run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            got  = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL shadow i=%0d got=%h want=%h", i, got, want);
            end
            if (i == 3) bus.rend = CW'(8);
            if (i == 13) begin
                bus.rstart = CW'(4);
                bus.rend   = CW'(4);
            end
        end
        bus.run = 1'b0;
    endtask

    task automatic test_stop_and_reset();
        do_reset();
        set_cfg(10, 2, 5, 6, 9, 1'b1);
        bus.frame_adj = CW'(-3);
        for (int k = 0; k < 7; k++) push_exp(k == 0, k >= 2 && k < 5, k >= 6, k >= 3, k);
        push_exp(0, 0, 0, 1, 0);
        push_frame(10, 0, 2, 5, 6, 9, 1'b1);
        for (int k = 0; k < 5; k++) push_exp(k == 0, k >= 2, 1'b0, k >= 2, k);
        push_exp(0, 0, 0, 0, 0);
        push_frame(10, 99, 2, 5, 6, 9, 1'b1);
        push_exp(1, 0, 0, 0, 0);
        bus.run = 1'b1;
        for (int i = 0; i < 35; i++) begin
            cyc();
            got  = {bus.sync, bus.ien, bus.oen, bus.adj_pending, bus.fcnt};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL stop_reset i=%0d got=%h want=%h", i, got, want);
            end
            bus.adj_req = (i == 2) || (i == 19);
            if (i == 6) bus.run = 1'b0;
            if (i == 7) bus.run = 1'b1;
            rst = (i == 22);
        end
        bus.run     = 1'b0;
        bus.adj_req = 1'b0;
        rst         = 1'b0;
    endtask

    initial begin
        bus.run       = 1'b0;
        bus.adj_req   = 1'b0;
        bus.frame_adj = '0;
        set_cfg(0, 0, 0, 0, 0, 1'b0);
        test_reset();
        test_tdd_windows();
        test_fdd_and_minlen();
        test_adjust_mid_frame();
        test_adjust_boundary();
        test_shadow_update();
        test_stop_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
